// File: rtl/alu_wb_stage.sv
// ALU writeback stage: 2-entry skid buffer toward the register file, with Z/N/C/V flags committed on pop.
// Optional macro ALU_WB_FORWARD_EN adds bypass outputs that mirror the youngest buffered entry with wr_en=1.
module alu_wb_stage #(
    parameter int DW = 32,
    parameter int RW = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [4:0]    i_op,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic [DW-1:0] i_result,
    input  logic [RW-1:0] i_rd,
    input  logic          i_wr_en,
    input  logic          i_setflags,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_result,
    output logic [RW-1:0] o_rd,
    output logic          o_wr_en,
    output logic [7:0]    o_flags
`ifdef ALU_WB_FORWARD_EN
    ,
    output logic          o_fwd_valid,
    output logic [RW-1:0] o_fwd_rd,
    output logic [DW-1:0] o_fwd_data
`endif
);

    localparam logic [3:0] OP_SUB = 4'd0;
    localparam logic [3:0] OP_AND = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;

    // c_upd/v_upd mark flags the entry actually defines; the others keep
    // whatever o_flags holds at commit time, not at capture time.
    typedef struct packed {
        logic [DW-1:0] result;
        logic [RW-1:0] rd;
        logic          wr_en;
        logic          setflags;
        logic          z;
        logic          n;
        logic          c;
        logic          v;
        logic          c_upd;
        logic          v_upd;
    } entry_t;

    entry_t      cap;
    entry_t      head;
    entry_t      tail;
    logic [1:0]  count;
    logic [3:0]  flags;
    logic [3:0]  flags_next;
    logic [DW:0] add_sum;
    logic        push;
    logic        pop;
    logic [DW:0] unused_bits;

    assign add_sum     = {1'b0, i_a} + {1'b0, i_b};
    assign unused_bits = {i_op[4], add_sum[DW-1:0]};

    always_comb begin
        cap          = '0;
        cap.result   = i_result;
        cap.rd       = i_rd;
        cap.wr_en    = i_wr_en;
        cap.setflags = i_setflags;
        cap.z        = (i_result == '0);
        cap.n        = i_result[DW-1];
        case (i_op[3:0])
            OP_SUB: begin
                cap.c     = (i_a >= i_b);
                cap.v     = (i_a[DW-1] != i_b[DW-1]) && (i_result[DW-1] != i_a[DW-1]);
                cap.c_upd = 1'b1;
                cap.v_upd = 1'b1;
            end
            OP_ADD: begin
                cap.c     = add_sum[DW];
                cap.v     = (i_a[DW-1] == i_b[DW-1]) && (i_result[DW-1] != i_a[DW-1]);
                cap.c_upd = 1'b1;
                cap.v_upd = 1'b1;
            end
            OP_AND, OP_OR, OP_XOR: begin
                cap.v     = 1'b0;
                cap.v_upd = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign o_ready = (count != 2'd2);
    assign o_valid = (count != 2'd0);
    assign push    = i_valid && o_ready;
    assign pop     = o_valid && i_ready;

    assign o_result = head.result;
    assign o_rd     = head.rd;
    assign o_wr_en  = o_valid && head.wr_en;
    assign o_flags  = {4'b0000, flags};

    always_comb begin
        flags_next    = flags;
        flags_next[0] = head.z;
        flags_next[1] = head.n;
        if (head.c_upd) begin
            flags_next[2] = head.c;
        end
        if (head.v_upd) begin
            flags_next[3] = head.v;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
            flags <= 4'h0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head <= cap;
                    end else begin
                        tail <= cap;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        head <= tail;
                    end
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Only reachable with count=1: the new entry replaces the departing head.
                    head <= cap;
                end
                default: begin
                end
            endcase
            if (pop && head.setflags) begin
                flags <= flags_next;
            end
        end
    end

`ifdef ALU_WB_FORWARD_EN
    always_comb begin
        o_fwd_valid = 1'b0;
        o_fwd_rd    = '0;
        o_fwd_data  = '0;
        if ((count == 2'd2) && tail.wr_en) begin
            o_fwd_valid = 1'b1;
            o_fwd_rd    = tail.rd;
            o_fwd_data  = tail.result;
        end else if ((count != 2'd0) && head.wr_en) begin
            o_fwd_valid = 1'b1;
            o_fwd_rd    = head.rd;
            o_fwd_data  = head.result;
        end
    end
`endif

endmodule

// File: doc/alu_wb_stage.md
Name: alu_wb_stage

Overview:
Writeback stage directly downstream of the ALU. Captures each ALU result together with its operands and opcode, and derives the Z/N/C/V condition flags. Holds results in a 2-entry skid buffer with a valid/ready handshake toward the register-file write port. Commits the architectural flags register only when an entry is accepted downstream.

Parameters:
DW, 32, datapath width of the operands and result
RW, 4, register-index width of the destination field

Ports:
i_clk  input  1  clock; all state changes on the rising edge
i_reset  input  1  reset; asynchronous, active-low
i_valid  input  1  upstream entry present
o_ready  output  1  stage can accept an entry this cycle
i_op  input  5  ALU opcode of this entry
i_a  input  DW  ALU operand A
i_b  input  DW  ALU operand B
i_result  input  DW  ALU result
i_rd  input  RW  destination register index
i_wr_en  input  1  entry writes the register file
i_setflags  input  1  entry updates the flags register
o_valid  output  1  head entry present
i_ready  input  1  downstream accepts the head entry
o_result  output  DW  head result
o_rd  output  RW  head destination index
o_wr_en  output  1  head write enable; gated with o_valid
o_flags  output  8  architectural flags: [0]=Z, [1]=N, [2]=C, [3]=V, [7:4]=0

Behaviour:
- Reset (i_reset low, asynchronous): buffer emptied; o_valid=0, o_ready=1, o_flags=8'h00, o_result=0, o_rd=0, o_wr_en=0. Reset asserted mid-operation discards all buffered entries.
- Push: occurs when i_valid && o_ready. Pop: occurs when o_valid && i_ready. Both are evaluated on the same edge.
- o_ready = (count < 2), driven from registered state only; no combinational path from i_ready.
- Latency: an entry pushed at edge N is visible on o_valid/o_result after edge N. Throughput is 1 entry/cycle when not stalled.
- FIFO order is strict. Push and pop on the same edge with count=1 leaves count=1 and the new entry at the head.
- count=2: o_ready=0, so push is impossible. A pop takes count to 1.
- count=0: o_valid=0, o_wr_en=0, o_result and o_rd hold their last values.
- Flag derivation is combinational from the i_* inputs at capture time. Candidate flags are stored per entry with their i_setflags bit. Opcode encodings: SUB=0, AND=1, ADD=2, OR=3, XOR=4, LSR=5, LSL=6, ASR=7. Bit 4 of i_op is ignored.
  - Z = (i_result == 0); N = i_result[DW-1]. Both apply to all ops.
  - ADD: C = carry out of the (DW+1)-bit sum i_a + i_b. V = (a[msb]==b[msb]) && (result[msb]!=a[msb]).
  - SUB: C = no-borrow, i.e. i_a >= i_b unsigned. V = (a[msb]!=b[msb]) && (result[msb]!=a[msb]).
  - AND/OR/XOR: C keeps its old value; V=0.
  - LSR/LSL/ASR and undefined ops: C and V keep their old values.
  - "Old value" means the o_flags value at the moment the entry is committed, not at capture.
- Commit: on pop with the entry's setflags=1, o_flags updates on that edge. Entries with setflags=0 leave o_flags unchanged.

Optional Feature:
ALU_WB_FORWARD_EN
- Defined: extra outputs o_fwd_valid (1), o_fwd_rd (RW), o_fwd_data (DW), so decode can bypass the register file.
  - These mirror the youngest buffered entry whose wr_en=1.
  - o_fwd_valid=0 when no such entry exists. All three are 0 during reset.
- Undefined: these ports do not exist; no forwarding logic is built.

Test Plan:
- Hold i_reset low with 2 entries buffered and o_flags=0x0A -> o_valid=0, o_ready=1, o_flags=0x00 immediately, without waiting for a clock edge; after release the first push appears one cycle later.
- ADD, a=0xFFFFFFFF, b=1, result=0, setflags=1, i_ready=1 -> o_valid next cycle with o_result=0; after pop o_flags=0x05 (Z, C).
- SUB, a=5, b=7, result=0xFFFFFFFE, setflags=1 -> o_flags=0x02 (N set; C=0 for borrow; V=0). Follow with XOR result=0 -> o_flags=0x01 (C stays 0, V cleared).
- ADD, a=0x7FFFFFFF, b=1, result=0x80000000 -> o_flags=0x0A (N, V). Then SUB with setflags=0 -> o_flags stays 0x0A.
- Backpressure: i_ready=0, present 3 entries rd=1,2,3 -> o_ready falls after 2 pushes and entry 3 is held upstream; raise i_ready -> rd 1, 2, 3 pop in order, one per cycle, with none lost or duplicated.
- With ALU_WB_FORWARD_EN: push rd=4 (wr_en=1, data 0x11), then rd=5 (wr_en=0), i_ready=0 -> o_fwd_valid=1, o_fwd_rd=4, o_fwd_data=0x11; after both pops o_fwd_valid=0.
